// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, arbiter state encoding and rate constants.
package uart_pkg;

    localparam int BYTE_WIDTH = 8;

    // System clock and line rate; one bit time in clk cycles, rounded to nearest.
    localparam int CLOCK_RATE = 10_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int BIT_CYCLES = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } arb_state_t;

    // Width of a counter that must hold values up to maxVal (never narrower than 1 bit).
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first requester with req set, searching ptr+1 .. ptr (mod NUM_REQ).
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         winner,
    output logic                       anyValid
);
    localparam int PTR_W = $clog2(NUM_REQ);

    int               idx;
    logic [PTR_W-1:0] idxW;

    // Scan from the farthest slot towards ptr+1 so the nearest valid slot overwrites last.
    always_comb begin
        winner   = '0;
        anyValid = |req;
        idx      = 0;
        idxW     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx  = (int'(ptr) + k) % NUM_REQ;
            idxW = PTR_W'(idx);
            if (req[idxW]) begin
                winner       = '0;
                winner[idxW] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter among NUM_REQ requesters. A grant is held for a
// whole message (up to reqLast), followed by a forced idle gap; a stalled owner is dropped.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = BIT_CYCLES,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*BYTE_WIDTH-1:0] reqData,
    input  logic [NUM_REQ-1:0]            reqLast,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic                          txValid,
    output logic [BYTE_WIDTH-1:0]         txData,
    input  logic                          txReady,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          abort
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int GAP_W = cntWidth(GAP_CYCLES);
    localparam int TO_W  = cntWidth(TIMEOUT_CYCLES);

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [GAP_W-1:0]   gapCnt;
    logic [TO_W-1:0]    toCnt;

    logic [NUM_REQ-1:0] pickOneHot;
    logic               anyReq;
    logic [PTR_W-1:0]   pickIdx;
    logic               ownerValid;
    logic               ownerLast;
    logic               msgDone;
    logic               timedOut;

    rr_picker #(.NUM_REQ(NUM_REQ)) uPicker (
        .req      (reqValid),
        .ptr      (ptr),
        .winner   (pickOneHot),
        .anyValid (anyReq)
    );

    // Encode the picker's one-hot winner into the index kept as the rotation pointer.
    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickOneHot[i]) pickIdx = PTR_W'(i);
        end
    end

    // Steer the owner's lane to the transmitter; nothing passes outside STREAM.
    always_comb begin
        ownerValid = 1'b0;
        ownerLast  = 1'b0;
        txData     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                ownerValid = reqValid[i];
                ownerLast  = reqLast[i];
            end
        end
        txValid  = (state == STREAM) && ownerValid;
        reqReady = (state == STREAM) ? (grant & {NUM_REQ{txReady}}) : '0;
        if (txValid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) txData = reqData[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Only an owner stall (reqValid low) counts towards the timeout, never txReady backpressure.
    assign msgDone  = txValid && txReady && ownerLast;
    assign timedOut = (state == STREAM) && !ownerValid && (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign busy     = (state != IDLE);

    // Arbitration FSM: grant, rotation pointer, gap and stall counters, abort pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            abort  <= 1'b0;
            ptr    <= PTR_W'(NUM_REQ - 1);
            gapCnt <= '0;
            toCnt  <= '0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grant <= pickOneHot;
                        ptr   <= pickIdx;
                        toCnt <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (msgDone || timedOut) begin
                        grant <= '0;
                        toCnt <= '0;
                        abort <= timedOut;
                        if (GAP_CYCLES > 0) begin
                            gapCnt <= GAP_W'(GAP_CYCLES);
                            state  <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (ownerValid) begin
                        toCnt <= '0;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_W'(1)) state <= IDLE;
                    else                     gapCnt <= gapCnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester drivers feed message queues, a message-level
// reference model predicts ownership/gap/abort, and a negedge monitor scores every cycle.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N   = 4;
    localparam int GAP = 87;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT
    logic           reset    = 1'b1;
    logic [N-1:0]   reqValid = '0;
    logic [N-1:0]   reqLast  = '0;
    logic [N*8-1:0] reqData  = '0;
    logic           txReady  = 1'b1;
    logic [N-1:0]   reqReady, grant;
    logic           txValid, busy, abort;
    logic [7:0]     txData;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
        .reqReady(reqReady), .txValid(txValid), .txData(txData), .txReady(txReady),
        .grant(grant), .busy(busy), .abort(abort)
    );

    // no-gap DUT
    logic        reset1 = 1'b1;
    logic [1:0]  rv1 = '0, rl1 = '0;
    logic [15:0] rd1 = '0;
    logic        tr1 = 1'b1;
    logic [1:0]  rr1, g1;
    logic        tv1, busy1, abort1;
    logic [7:0]  td1;

    uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .reset(reset1), .reqValid(rv1), .reqData(rd1), .reqLast(rl1),
        .reqReady(rr1), .txValid(tv1), .txData(td1), .txReady(tr1),
        .grant(g1), .busy(busy1), .abort(abort1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         gapBefore;
        logic       last;
        logic [7:0] data;
    } ent_t;

    ent_t       drvQ[N][$];
    logic [7:0] expQ[N][$];
    bit         present[N];
    int         waitc[N];
    logic [N-1:0] acc = '0;
    int         rstCycles = 2;
    bit         trRand = 1'b0;
    bit         trPat[$];

    // reference model state (message level)
    int mOwner = -1, mPtr = N - 1, mGap = 0, mStall = 0;
    bit mAbort = 1'b0, inited = 1'b0;
    int grantLog[$];
    logic [N-1:0] prevGrant = '0;
    int abortSeen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pushByte(input int r, input int gapBefore, input logic last, input logic [7:0] d);
        ent_t e;
        e.gapBefore = gapBefore;
        e.last      = last;
        e.data      = d;
        drvQ[r].push_back(e);
        expQ[r].push_back(d);
    endtask

    task automatic sendSeq(input int r, input int len, input int gap0, input logic [7:0] base);
        for (int b = 0; b < len; b++)
            pushByte(r, (b == 0) ? gap0 : 0, b == len - 1, 8'(int'(base) + b * 17));
    endtask

    function automatic bit drained();
        bit d = (mOwner < 0) && (mGap == 0);
        for (int i = 0; i < N; i++) if (drvQ[i].size() != 0 || present[i]) d = 1'b0;
        return d;
    endfunction

    task automatic waitDrain(input string name, input int maxc);
        int n = 0;
        while (!drained() && n < maxc) begin
            @(posedge clk);
            n++;
        end
        check({name, " drain"}, 32'(n < maxc), 32'd1);
    endtask

    // Requester drivers and txReady source, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rstCycles > 0) begin
            reset = 1'b1;
            rstCycles--;
            for (int i = 0; i < N; i++) begin
                drvQ[i].delete();
                expQ[i].delete();
                present[i] = 1'b0;
                waitc[i]   = 0;
            end
            reqValid = '0;
            reqLast  = '0;
            reqData  = '0;
        end else begin
            reset = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    drvQ[i].delete(0);
                    present[i] = 1'b0;
                end
                if (!present[i] && drvQ[i].size() > 0) begin
                    if (waitc[i] < drvQ[i][0].gapBefore) waitc[i]++;
                    else begin
                        present[i] = 1'b1;
                        waitc[i]   = 0;
                    end
                end
                reqValid[i]       = present[i];
                reqLast[i]        = present[i] ? drvQ[i][0].last : 1'b0;
                reqData[i*8 +: 8] = present[i] ? drvQ[i][0].data : 8'h00;
            end
        end
        if (trPat.size() > 0) txReady = trPat.pop_front();
        else if (trRand)      txReady = ($urandom_range(3) != 0);
        else                  txReady = 1'b1;
    end

    // Monitor + model: compare this cycle's outputs, then advance the model across the edge.
    initial forever begin
        int           o;
        logic [N-1:0] eGrant, eReady;
        bit           eValid, eBusy;
        @(negedge clk);
        cyc++;
        acc = reqValid & reqReady;
        o   = mOwner;
        if (inited) begin
            eGrant = (o >= 0) ? (N'(1) << o) : '0;
            eValid = (o >= 0) ? reqValid[o] : 1'b0;
            eBusy  = (o >= 0) || (mGap > 0);
            eReady = (o >= 0 && txReady) ? eGrant : '0;
            check("grant",    32'(grant),    32'(eGrant));
            check("txValid",  32'(txValid),  32'(eValid));
            check("busy",     32'(busy),     32'(eBusy));
            check("abort",    32'(abort),    32'(mAbort));
            check("reqReady", 32'(reqReady), 32'(eReady));
            if (eValid) begin
                if (expQ[o].size() == 0) check("txData unexpected byte", 32'(txData), 32'h100);
                else                     check("txData", 32'(txData), 32'(expQ[o][0]));
            end else begin
                check("txData idle", 32'(txData), 32'h0);
            end
            if (grant != '0 && prevGrant == '0)
                for (int i = 0; i < N; i++) if (grant[i]) grantLog.push_back(i);
            if (abort === 1'b1) abortSeen++;
            prevGrant = grant;
        end
        if (reset) begin
            mOwner = -1; mPtr = N - 1; mGap = 0; mStall = 0; mAbort = 1'b0; inited = 1'b1;
        end else if (inited) begin
            mAbort = 1'b0;
            if (o >= 0) begin
                if (reqValid[o]) begin
                    mStall = 0;
                    if (txReady) begin
                        if (expQ[o].size() > 0) expQ[o].delete(0);
                        if (reqLast[o]) begin mOwner = -1; mGap = GAP; end
                    end
                end else begin
                    mStall++;
                    if (mStall == TMO) begin
                        mAbort = 1'b1; mOwner = -1; mGap = GAP; mStall = 0;
                    end
                end
            end else if (mGap > 0) begin
                mGap--;
            end else if (reqValid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (mOwner < 0 && reqValid[(mPtr + k) % N]) mOwner = (mPtr + k) % N;
                end
                mPtr   = mOwner;
                mStall = 0;
            end
        end
    end

    initial begin
        int         nX;
        int         xCyc[4];
        logic [7:0] xDat[4];
        logic [1:0] xGnt[4];
        logic [1:0] acc1;
        logic [6:0] pat;

        repeat (4) @(posedge clk);

        // all four requesters with 2-byte messages; requester 0 queues a second message
        grantLog.delete();
        for (int r = 0; r < N; r++) sendSeq(r, 2, 0, 8'(8'h40 + r * 16));
        sendSeq(0, 2, 0, 8'hA0);
        waitDrain("rr4", 3000);
        check("rr4 grants", 32'(grantLog.size()), 32'd5);
        for (int i = 0; i < 5 && i < grantLog.size(); i++) check("rr4 order", 32'(grantLog[i]), 32'(i % 4));

        // single requester 1 message 11,22,33 with txReady high
        grantLog.delete();
        sendSeq(1, 3, 0, 8'h11);
        waitDrain("req1", 500);
        check("req1 grants", 32'(grantLog.size()), 32'd1);
        if (grantLog.size() > 0) check("req1 owner", 32'(grantLog[0]), 32'd1);

        // requester 2 under txReady backpressure
        pat = 7'b1100101;
        for (int i = 6; i >= 0; i--) trPat.push_back(pat[i]);
        sendSeq(2, 3, 0, 8'h5A);
        waitDrain("bp", 500);

        // requester 3 stalls after a non-last byte while requester 0 waits
        grantLog.delete();
        abortSeen = 0;
        pushByte(3, 0, 1'b0, 8'hAA);
        sendSeq(0, 2, 3, 8'hC3);
        waitDrain("timeout", 2500);
        check("timeout abort pulses", 32'(abortSeen), 32'd1);
        check("timeout grants", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() > 1) begin
            check("timeout first owner", 32'(grantLog[0]), 32'd3);
            check("timeout next owner", 32'(grantLog[1]), 32'd0);
        end

        // reset mid-message from requester 0
        sendSeq(0, 4, 0, 8'h70);
        repeat (3) @(posedge clk);
        rstCycles = 1;
        @(posedge clk);
        @(negedge clk);
        check("post-reset grant",   32'(grant),   32'd0);
        check("post-reset txValid", 32'(txValid), 32'd0);
        check("post-reset abort",   32'(abort),   32'd0);
        @(posedge clk);
        grantLog.delete();
        sendSeq(1, 1, 0, 8'hB1);
        sendSeq(0, 1, 0, 8'hB0);
        waitDrain("post-reset", 500);
        if (grantLog.size() > 1) begin
            check("post-reset first owner", 32'(grantLog[0]), 32'd0);
            check("post-reset second owner", 32'(grantLog[1]), 32'd1);
        end else begin
            check("post-reset grants", 32'(grantLog.size()), 32'd2);
        end

        // randomized traffic with random txReady
        trRand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            int r   = $urandom_range(N - 1);
            int len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++)
                pushByte(r, (b == 0) ? $urandom_range(3) : (($urandom_range(3) == 0) ? $urandom_range(2) : 0),
                         b == len - 1, 8'($urandom));
            repeat ($urandom_range(40)) @(posedge clk);
        end
        waitDrain("random", 20000);
        trRand = 1'b0;

        // no-gap build: back-to-back single-byte messages from requesters 0 and 1
        @(posedge clk);
        #1;
        reset1 = 1'b0;
        rv1 = 2'b11; rl1 = 2'b11; rd1 = {8'hC1, 8'hC0}; tr1 = 1'b1;
        nX = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (tv1 && tr1 && nX < 4) begin
                xCyc[nX] = c; xDat[nX] = td1; xGnt[nX] = g1; nX++;
            end
            acc1 = rv1 & rr1;
            @(posedge clk);
            #1;
            rv1 = rv1 & ~acc1;
        end
        check("gap0 transfers", 32'(nX), 32'd2);
        if (nX >= 2) begin
            check("gap0 byte0", 32'(xDat[0]), 32'hC0);
            check("gap0 grant0", 32'(xGnt[0]), 32'd1);
            check("gap0 byte1", 32'(xDat[1]), 32'hC1);
            check("gap0 grant1", 32'(xGnt[1]), 32'd2);
            check("gap0 spacing", 32'(xCyc[1] - xCyc[0]), 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter among NUM_REQ requesters, e.g. adder result path, status reporter and debug echo.
- Uses round-robin arbitration.
- Holds each grant for a whole message, delimited by `reqLast`, so bytes from different requesters never interleave on `txd`.
- Sits between requester logic and the UartTx byte interface.
- Inserts a programmable idle gap between messages.
- Drops a stalled requester after a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 87, clk cycles of forced idle after each message end; 0 = no gap. 87 is one bit time at 10 MHz / 115200.
- TIMEOUT_CYCLES, 1000, consecutive clk cycles a granted requester may hold `reqValid` low mid-message before its grant is revoked.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  NUM_REQ  per-requester byte valid.
- reqData  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- reqLast  in  NUM_REQ  per-requester last-byte-of-message flag, qualified by reqValid.
- reqReady  out  NUM_REQ  per-requester byte accepted.
- txValid  out  1  byte valid toward transmitter.
- txData  out  8  byte toward transmitter.
- txReady  in  1  transmitter can accept a byte.
- grant  out  NUM_REQ  one-hot current owner; all-zero when none.
- busy  out  1  high in STREAM or GAP.
- abort  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state = IDLE; grant = 0; busy = 0; abort = 0; txValid = 0; txData = 0; reqReady = 0.
  - Round-robin pointer `ptr` = NUM_REQ-1, so requester 0 wins first.
  - Gap counter and timeout counter = 0.
- Reset mid-message: outputs return to reset values on the next edge. The partial message is dropped without an abort pulse.
- State IDLE:
  - If any reqValid is high, pick the first index with reqValid high searching `ptr+1, ptr+2, … ptr` (mod NUM_REQ).
  - Register grant one-hot, set `ptr` = winner, go to STREAM.
  - Arbitration latency: reqValid high at edge n gives grant/txValid high from cycle n+1.
  - No byte is accepted in IDLE.
- State STREAM (winner w):
  - Combinational outputs:
    - txValid = reqValid[w]
    - txData = reqData[w] when txValid, else 8'h00
    - reqReady[w] = txReady; all other reqReady = 0
  - A transfer occurs when txValid && txReady.
  - Transfer with reqLast[w] = 1: grant cleared on the next edge. Go to GAP if GAP_CYCLES>0 (counter loaded with GAP_CYCLES), else IDLE.
  - Timeout counter:
    - Increments each cycle reqValid[w] = 0.
    - Clears on any cycle reqValid[w] = 1.
    - On reaching TIMEOUT_CYCLES: pulse abort for one cycle, clear grant, go to GAP (or IDLE if GAP_CYCLES = 0).
  - Requests from other requesters are ignored. They keep their reqValid and are never dropped.
- State GAP:
  - txValid = 0, all reqReady = 0, busy = 1.
  - Counter decrements each cycle; on reaching 1, go to IDLE.
  - Exactly GAP_CYCLES cycles are spent in GAP.
- busy = 1 in STREAM and GAP, 0 in IDLE.
- Single requester repeatedly requesting: it wins again after the gap. Rotation only matters when several requesters are valid.
- Single-byte message (reqLast on first byte): legal; one transfer, then GAP.
- txReady low for long periods does not advance the timeout. Only a requester stall counts.
- The requester must hold reqData/reqLast stable while reqValid && !reqReady. The arbiter does not check this.

Decomposition:
- Package uart_pkg holds:
  - BYTE_WIDTH = 8.
  - enum arb_state_t {IDLE, STREAM, GAP}.
  - Shared UART rate constants (CLOCK_RATE, BAUD_RATE) used to derive GAP_CYCLES defaults.
- One sub-module: rr_picker (NUM_REQ). Inputs are the request vector and ptr. Output is the one-hot winner plus an any-valid flag. It is purely combinational and separately testable.

Test Plan:
- Reset, then requester 1 sends {8'h11, 8'h22, last 8'h33} with txReady stuck at 1 → grant = 4'b0010 one cycle after reqValid. txData sequence is 11, 22, 33 on consecutive cycles. Then 87 cycles of busy with txValid = 0, then IDLE.
- All four requesters valid with 2-byte messages → grant order is 0, 1, 2, 3, 0. No byte from another requester appears between a first byte and its last byte.
- Requester 2 granted while txReady toggles 1-0-0-1 → each byte held on txData until accepted. reqReady[2] mirrors txReady. Timeout counter stays 0.
- Requester 3 sends 8'hAA (not last), then drops reqValid for 1000 cycles → abort pulses exactly once at the 1000th idle cycle. Grant clears, then GAP. Requester 0 pending is then granted.
- Reset asserted for one cycle mid-message from requester 0 → next cycle grant = 0, txValid = 0, abort = 0. The first grant after reset goes to requester 0 (ptr = NUM_REQ-1).
- GAP_CYCLES = 0 build: back-to-back single-byte messages from requesters 0 and 1 → transfers are two cycles apart (one IDLE arbitration cycle) with no gap.
